maze_player_ctrl: RTL and testbench

MAZE_PLAYER_CTRL -- requirements
Module: maze_player_ctrl

---
 rtl/maze_player_ctrl.sv | 128 ++++++++++++
 tb/tb_maze_player_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: moves a player token around a ROM-backed maze.
// A move pulse latches a target cell, fetches that cell's map row from a
// registered ROM, and commits the move only if the target is not a wall.
// Optional feature: define MAZE_MOVE_COUNT_EN to build the saturating
// accepted-move counter; otherwise move_count is tied to zero.
module maze_player_ctrl #(
  parameter int MAP_W = 30,
  parameter int MAP_H = 21
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             BtnU_p,
  input  logic             BtnD_p,
  input  logic             BtnL_p,
  input  logic             BtnR_p,
  output logic [4:0]       map_addr,
  input  logic [MAP_W-1:0] map_data,
  output logic [4:0]       player_x,
  output logic [4:0]       player_y,
  output logic             busy,
  output logic             at_goal,
  output logic [15:0]      move_count
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK} state_t;

  localparam int         IDX_W  = $clog2(MAP_W);
  localparam logic [4:0] X_MAX  = 5'(MAP_W - 1);
  localparam logic [4:0] Y_MAX  = 5'(MAP_H - 1);
  localparam logic [4:0] GOAL_X = 5'(MAP_W - 2);
  localparam logic [4:0] GOAL_Y = 5'(MAP_H - 2);

  state_t           state;
  logic [4:0]       tx, ty;
  logic [4:0]       next_x, next_y;
  logic             move_req;
  logic [IDX_W-1:0] bit_idx;
  logic             wall;
  logic             move_ok;

  assign at_goal = (player_x == GOAL_X) && (player_y == GOAL_Y);

  // Pick the highest-priority pulse (U > D > L > R) and reject off-map targets.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    move_req = 1'b0;
    next_x   = player_x;
    next_y   = player_y;
    if (BtnU_p) begin
      move_req = (player_y != 5'd0);
      next_y   = player_y - 5'd1;
    end else if (BtnD_p) begin
      move_req = (player_y != Y_MAX);
      next_y   = player_y + 5'd1;
    end else if (BtnL_p) begin
      move_req = (player_x != 5'd0);
      next_x   = player_x - 5'd1;
    end else if (BtnR_p) begin
      move_req = (player_x != X_MAX);
      next_x   = player_x + 5'd1;
    end
  end

  // Column x lives at bit (MAP_W-1-x) of the ROM row.
  assign bit_idx = IDX_W'(MAP_W - 1) - tx[IDX_W-1:0];
  assign wall    = map_data[bit_idx];
  assign move_ok = (state == CHECK) && !wall;

  // Move FSM: latch target, wait one edge for the ROM, then commit or discard.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state    <= IDLE;
      tx       <= 5'd1;
      ty       <= 5'd1;
      player_x <= 5'd1;
      player_y <= 5'd1;
      map_addr <= 5'd1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_req && !at_goal) begin
            tx       <= next_x;
            ty       <= next_y;
            map_addr <= next_y;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= CHECK;
        end
        CHECK: begin
          if (!wall) begin
            player_x <= tx;
            player_y <= ty;
            map_addr <= ty;
          end else begin
            map_addr <= player_y;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAZE_MOVE_COUNT_EN
  // Count accepted moves, holding at the maximum instead of wrapping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      move_count <= 16'h0000;
    end else if (move_ok && (move_count != 16'hFFFF)) begin
      move_count <= move_count + 16'd1;
    end
  end
`else
  logic unused_move_ok;
  assign unused_move_ok = move_ok;
  assign move_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Self-checking bench for maze_player_ctrl with a behavioural registered ROM.
module tb_maze_player_ctrl;

  localparam int W = 30;
  localparam int H = 21;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          BtnU_p = 1'b0, BtnD_p = 1'b0, BtnL_p = 1'b0, BtnR_p = 1'b0;
  logic [4:0]    map_addr;
  logic [W-1:0]  map_data;
  logic [4:0]    player_x, player_y;
  logic          busy, at_goal;
  logic [15:0]   move_count;

  logic [W-1:0]  rom [0:31];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0] btn;   // {U, D, L, R}
    logic       busy;
    logic [4:0] x;
    logic [4:0] y;
    int         n;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  maze_player_ctrl #(.MAP_W(W), .MAP_H(H)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnU_p(BtnU_p), .BtnD_p(BtnD_p), .BtnL_p(BtnL_p), .BtnR_p(BtnR_p),
    .map_addr(map_addr), .map_data(map_data),
    .player_x(player_x), .player_y(player_y),
    .busy(busy), .at_goal(at_goal), .move_count(move_count)
  );

  always #5 Clk = ~Clk;

  // Registered map ROM.
  always @(posedge Clk) map_data <= rom[map_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] cnt_exp(input int n);
`ifdef MAZE_MOVE_COUNT_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill_open();
    for (int r = 0; r < 32; r++) begin
      if (r == 0 || r >= H - 1) rom[r] = '1;
      else rom[r] = (W'(1) << (W - 1)) | W'(1);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk); Reset = 1'b0;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {BtnU_p, BtnD_p, BtnL_p, BtnR_p} = b;
  endtask

  // One pulse, then sample after edge 0, edge 1 and edge 2.
  task automatic do_move(input string tag, input logic [3:0] btn, input logic exp_busy,
                         input logic [4:0] ex, input logic [4:0] ey, input int en);
    exp_t e;
    sb.push_back(exp_t'{ex, ey, cnt_exp(en)});
    @(negedge Clk); set_btn(btn);
    @(negedge Clk); set_btn(4'b0000);
    check({tag, "_busy_fetch"}, 32'(busy), 32'(exp_busy));
    @(negedge Clk);
    check({tag, "_busy_check"}, 32'(busy), 32'(exp_busy));
    @(negedge Clk);
    e = sb.pop_front();
    check({tag, "_x"}, 32'(player_x), 32'(e.x));
    check({tag, "_y"}, 32'(player_y), 32'(e.y));
    check({tag, "_cnt"}, 32'(move_count), 32'(e.cnt));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acc;
    exp_t e;

    // From (1,1) on the open map.
    vecs[0] = '{4'b0001, 1'b1, 5'd2, 5'd1, 1};  // right
    vecs[1] = '{4'b0100, 1'b1, 5'd2, 5'd2, 2};  // down
    vecs[2] = '{4'b0010, 1'b1, 5'd1, 5'd2, 3};  // left
    vecs[3] = '{4'b1010, 1'b1, 5'd1, 5'd1, 4};  // up+left: up wins
    vecs[4] = '{4'b1000, 1'b1, 5'd1, 5'd1, 4};  // up into top border wall
    vecs[5] = '{4'b0010, 1'b1, 5'd1, 5'd1, 4};  // left into left border wall
    vecs[6] = '{4'b0101, 1'b1, 5'd1, 5'd2, 5};  // down+right: down wins
    vecs[7] = '{4'b1000, 1'b1, 5'd1, 5'd1, 6};  // up

    fill_open();
    Reset = 1'b1;
    #12;
    check("rst_x", 32'(player_x), 32'd1);
    check("rst_y", 32'(player_y), 32'd1);
    check("rst_addr", 32'(map_addr), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_goal", 32'(at_goal), 32'd0);
    check("rst_cnt", 32'(move_count), 32'd0);
    @(negedge Clk); Reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_move($sformatf("vec%0d", i), vecs[i].btn, vecs[i].busy, vecs[i].x, vecs[i].y, vecs[i].n);

    // Wall at column 2 of row 1: move rejected, ROM addressed at row 1.
    do_reset();
    rom[1][27] = 1'b1;
    sb.push_back(exp_t'{5'd1, 5'd1, cnt_exp(0)});
    @(negedge Clk); set_btn(4'b0001);
    @(negedge Clk); set_btn(4'b0000);
    check("wall_busy_fetch", 32'(busy), 32'd1);
    check("wall_addr_fetch", 32'(map_addr), 32'd1);
    @(negedge Clk);
    check("wall_busy_check", 32'(busy), 32'd1);
    check("wall_addr_check", 32'(map_addr), 32'd1);
    @(negedge Clk);
    e = sb.pop_front();
    check("wall_x", 32'(player_x), 32'(e.x));
    check("wall_y", 32'(player_y), 32'(e.y));
    check("wall_cnt", 32'(move_count), 32'(e.cnt));
    check("wall_busy_done", 32'(busy), 32'd0);
    fill_open();

    // A pulse arriving while busy is dropped, not queued.
    do_reset();
    sb.push_back(exp_t'{5'd1, 5'd2, cnt_exp(1)});
    @(negedge Clk); set_btn(4'b0100);
    @(negedge Clk); set_btn(4'b0001);
    check("drop_busy", 32'(busy), 32'd1);
    @(negedge Clk); set_btn(4'b0000);
    @(negedge Clk);
    e = sb.pop_front();
    check("drop_x", 32'(player_x), 32'(e.x));
    check("drop_y", 32'(player_y), 32'(e.y));
    @(negedge Clk);
    check("drop_idle", 32'(busy), 32'd0);
    @(negedge Clk);
    check("drop_x_later", 32'(player_x), 32'd1);

    // Opened left column: reach (0,5), then a left pulse is off-map.
    do_reset();
    for (int r = 1; r <= 5; r++) rom[r][W-1] = 1'b0;
    for (int j = 0; j < 4; j++)
      do_move($sformatf("col0_d%0d", j), 4'b0100, 1'b1, 5'd1, 5'(2 + j), j + 1);
    do_move("col0_l", 4'b0010, 1'b1, 5'd0, 5'd5, 5);
    do_move("offmap", 4'b0010, 1'b0, 5'd0, 5'd5, 5);
    check("offmap_addr", 32'(map_addr), 32'd5);
    fill_open();

    // Walk to the goal cell; further pulses are ignored until reset.
    do_reset();
    acc = 0;
    for (int i = 0; i < W - 3; i++) begin
      acc++;
      do_move($sformatf("goal_r%0d", i), 4'b0001, 1'b1, 5'(2 + i), 5'd1, acc);
    end
    check("goal_not_yet", 32'(at_goal), 32'd0);
    for (int j = 0; j < H - 3; j++) begin
      acc++;
      do_move($sformatf("goal_d%0d", j), 4'b0100, 1'b1, 5'(W - 2), 5'(2 + j), acc);
    end
    check("goal_set", 32'(at_goal), 32'd1);
    do_move("goal_lock_u", 4'b1000, 1'b0, 5'(W - 2), 5'(H - 2), acc);
    do_move("goal_lock_l", 4'b0010, 1'b0, 5'(W - 2), 5'(H - 2), acc);
    do_reset();
    check("goal_rst_x", 32'(player_x), 32'd1);
    check("goal_rst_y", 32'(player_y), 32'd1);
    check("goal_rst_flag", 32'(at_goal), 32'd0);

    // Reset during CHECK aborts the pending move.
    @(negedge Clk); set_btn(4'b0001);
    @(negedge Clk); set_btn(4'b0000);
    @(negedge Clk);
    check("abort_in_check", 32'(busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("abort_x", 32'(player_x), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(map_addr), 32'd1);
    @(negedge Clk);
    @(negedge Clk); Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("abort_x_after", 32'(player_x), 32'd1);
    check("abort_y_after", 32'(player_y), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_cnt", 32'(move_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
